// File: rtl/dvs_event_scheduler.sv
// Buffers decoded DVS events in a small FIFO, maps them to RAVENS input-neuron
// indices, and paces RAVENS in fixed timesteps: collect, drain the captured events, run, wait.
module dvs_event_scheduler #(
  parameter int FIFO_DEPTH      = 8,
  parameter int ADDR_W          = 10,
  parameter int TIMESTEP_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          evt_valid,
  input  logic [ADDR_W-1:0]             evt_x,
  input  logic [ADDR_W-1:0]             evt_y,
  input  logic                          evt_pol,
  output logic                          spk_valid,
  output logic [7:0]                    spk_idx,
  input  logic                          spk_ready,
  output logic                          run_req,
  input  logic                          run_done,
  output logic [15:0]                   step_cnt,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int TICK_W = $clog2(TIMESTEP_CYCLES);
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMESTEP_CYCLES - 1);

  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_RUN, S_WAIT_DONE} state_t;

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   r_drain_rem;
  logic [TICK_W-1:0]  r_tick;
  logic [15:0]        r_step_cnt;
  logic [15:0]        r_drop_cnt;
  logic               r_run_req;

  logic               w_full;
  logic               w_evt;
  logic               w_push;
  logic               w_drop;
  logic               w_spk_valid;
  logic               w_pop;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [7:0]         w_idx;

  assign w_full      = (r_level == DEPTH_L);
  assign w_evt       = evt_valid && enable;
  assign w_push      = w_evt && !w_full;
  assign w_drop      = w_evt && w_full;
  // In DRAIN only the events captured before the boundary are offered.
  assign w_spk_valid = ((r_state == S_COLLECT) && (r_level != '0)) ||
                       ((r_state == S_DRAIN) && (r_drain_rem != '0));
  assign w_pop       = w_spk_valid && spk_ready;
  assign w_level_nxt = r_level + {{(LVL_W-1){1'b0}}, w_push} - {{(LVL_W-1){1'b0}}, w_pop};
  assign w_idx       = {evt_pol, evt_y[ADDR_W-1 -: 3], evt_x[ADDR_W-1 -: 4]};

  assign spk_valid  = w_spk_valid;
  assign spk_idx    = w_spk_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign run_req    = r_run_req;
  assign step_cnt   = r_step_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_COLLECT;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_drain_rem <= '0;
      r_tick      <= '0;
      r_step_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_run_req   <= 1'b0;
    end else begin
      r_run_req <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;

      case (r_state)
        S_COLLECT: begin
          if (enable) begin
            if (r_tick == TICK_LAST) begin
              r_tick      <= '0;
              r_drain_rem <= w_level_nxt;
              if (w_level_nxt == '0) begin
                r_state   <= S_RUN;
                r_run_req <= 1'b1;
              end else begin
                r_state   <= S_DRAIN;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_drain_rem <= r_drain_rem - 1'b1;
            if (r_drain_rem == {{(LVL_W-1){1'b0}}, 1'b1}) begin
              r_state   <= S_RUN;
              r_run_req <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (run_done) begin
            r_step_cnt <= r_step_cnt + 16'd1;
            r_state    <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dvs_event_scheduler.sv
// Directed bench for dvs_event_scheduler with a 16-cycle timestep and an 8-entry FIFO.
module tb_dvs_event_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        evt_valid = 1'b0;
  logic [9:0]  evt_x = '0;
  logic [9:0]  evt_y = '0;
  logic        evt_pol = 1'b0;
  logic        spk_valid;
  logic [7:0]  spk_idx;
  logic        spk_ready = 1'b0;
  logic        run_req;
  logic        run_done = 1'b0;
  logic [15:0] step_cnt;
  logic [15:0] drop_cnt;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  int run_cnt = 0;

  dvs_event_scheduler #(.FIFO_DEPTH(8), .ADDR_W(10), .TIMESTEP_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .evt_valid(evt_valid),
    .evt_x(evt_x), .evt_y(evt_y), .evt_pol(evt_pol),
    .spk_valid(spk_valid), .spk_idx(spk_idx), .spk_ready(spk_ready),
    .run_req(run_req), .run_done(run_done), .step_cnt(step_cnt),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Records every accepted spike and every run request.
  always @(posedge clk) begin
    if (rst_n && spk_valid && spk_ready) got.push_back(spk_idx);
    if (rst_n && run_req) run_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; evt_valid = 1'b0; spk_ready = 1'b0; run_done = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1; enable = 1'b1;
  endtask

  task automatic push_evt(input logic [9:0] x, input logic [9:0] y, input logic p);
    evt_x = x; evt_y = y; evt_pol = p; evt_valid = 1'b1;
    cyc();
    evt_valid = 1'b0;
  endtask

  task automatic wait_run(input int max_cyc, output int n);
    n = 0;
    while (run_req !== 1'b1 && n < max_cyc) begin
      cyc();
      n++;
    end
    if (run_req !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; evt_valid = 1'b0; spk_ready = 1'b0; run_done = 1'b0;
    cyc(); cyc();
    checks++;
    if ({spk_valid, spk_idx, run_req, fifo_level, step_cnt, drop_cnt} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b idx=%0h run=%0b lvl=%0d step=%0d drop=%0d, expected all 0",
               spk_valid, spk_idx, run_req, fifo_level, step_cnt, drop_cnt);
    end
  endtask

  task automatic test_basic_flow();
    int n;
    int base;
    int rbase;
    do_reset();
    base = got.size(); rbase = run_cnt;
    spk_ready = 1'b1;
    cyc(); cyc();
    push_evt(10'h3FF, 10'h000, 1'b1);
    checks++;
    if (spk_valid !== 1'b1 || spk_idx !== 8'h8F) begin
      errors++;
      $display("FAIL basic_spike: got v=%0b idx=%0h, expected v=1 idx=8f", spk_valid, spk_idx);
    end
    cyc();
    checks++;
    if (spk_valid !== 1'b0 || fifo_level !== 4'd0 || got.size() !== base + 1) begin
      errors++;
      $display("FAIL basic_pop: got v=%0b lvl=%0d accepted=%0d, expected v=0 lvl=0 accepted=1",
               spk_valid, fifo_level, got.size() - base);
    end
    wait_run(50, n);
    checks++;
    if (n !== 12) begin
      errors++;
      $display("FAIL basic_run_time: got %0d cycles to run_req, expected 12", n);
    end
    cyc();
    checks++;
    if (run_req !== 1'b0 || run_cnt !== rbase + 1) begin
      errors++;
      $display("FAIL basic_run_pulse: got run_req=%0b pulses=%0d, expected 0 and 1", run_req, run_cnt - rbase);
    end
    run_done = 1'b1; cyc(); run_done = 1'b0;
    checks++;
    if (step_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_step: got %0d, expected 1", step_cnt);
    end
  endtask

  task automatic test_boundary_drain();
    int n;
    int base;
    logic [7:0] exp_idx [5];
    exp_idx = '{8'h11, 8'hA2, 8'h33, 8'hC4, 8'h55};
    do_reset();
    base = got.size();
    cyc(); cyc();
    push_evt(10'h07F, 10'h0FF, 1'b0);
    push_evt(10'h080, 10'h100, 1'b1);
    push_evt(10'h0C0, 10'h180, 1'b0);
    checks++;
    if (fifo_level !== 4'd3 || spk_valid !== 1'b1 || spk_idx !== 8'h11) begin
      errors++;
      $display("FAIL drain_collect: got lvl=%0d v=%0b idx=%0h, expected 3 1 11", fifo_level, spk_valid, spk_idx);
    end
    repeat (11) cyc();
    spk_ready = 1'b1;
    push_evt(10'h100, 10'h200, 1'b1);
    push_evt(10'h140, 10'h280, 1'b0);
    wait_run(40, n);
    checks++;
    if (n !== 1 || fifo_level !== 4'd2 || got.size() !== base + 3) begin
      errors++;
      $display("FAIL drain_run: got wait=%0d lvl=%0d spikes=%0d, expected 1 2 3", n, fifo_level, got.size() - base);
    end
    cyc();
    checks++;
    if (spk_valid !== 1'b0 || fifo_level !== 4'd2) begin
      errors++;
      $display("FAIL drain_wait_done: got v=%0b lvl=%0d, expected 0 2", spk_valid, fifo_level);
    end
    run_done = 1'b1; cyc(); run_done = 1'b0;
    cyc(); cyc();
    checks++;
    if (got.size() !== base + 5 || fifo_level !== 4'd0 || step_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drain_next_collect: got spikes=%0d lvl=%0d step=%0d, expected 5 0 1",
               got.size() - base, fifo_level, step_cnt);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[base + k] !== exp_idx[k]) begin
          errors++;
          $display("FAIL drain_order[%0d]: got %0h, expected %0h", k, got[base + k], exp_idx[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    int base;
    do_reset();
    base = got.size();
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        checks++;
        if (fifo_level !== 4'd8 || drop_cnt !== 16'd1) begin
          errors++;
          $display("FAIL overflow_full: got lvl=%0d drop=%0d, expected 8 1", fifo_level, drop_cnt);
        end
        spk_ready = 1'b1;
      end
      push_evt(10'(i << 6), 10'h000, 1'b0);
    end
    checks++;
    if (fifo_level !== 4'd7 || drop_cnt !== 16'd2 || spk_idx !== 8'h01) begin
      errors++;
      $display("FAIL overflow_pop_full: got lvl=%0d drop=%0d idx=%0h, expected 7 2 01", fifo_level, drop_cnt, spk_idx);
    end
    wait_run(40, n);
    checks++;
    if (n !== 7 || got.size() !== base + 8 || drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL overflow_drain: got wait=%0d spikes=%0d drop=%0d, expected 7 8 2", n, got.size() - base, drop_cnt);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got[base + k] !== 8'(k)) begin
          errors++;
          $display("FAIL overflow_order[%0d]: got %0h, expected %0h", k, got[base + k], k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int sent;
    int guard;
    logic prev_v, prev_r, prev_run;
    logic [7:0] prev_idx;
    logic [7:0] exp_i;
    logic [4:0] ib;
    do_reset();
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL bp_drop_reset: got %0d, expected 0", drop_cnt);
    end
    base = got.size();
    sent = 0; guard = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_run = 1'b0; prev_idx = '0;
    while (got.size() < base + 20 && guard < 1500) begin
      if (prev_v && !prev_r) begin
        checks++;
        if (spk_valid !== 1'b1 || spk_idx !== prev_idx) begin
          errors++;
          $display("FAIL bp_stable: got v=%0b idx=%0h, expected v=1 idx=%0h", spk_valid, spk_idx, prev_idx);
        end
      end
      spk_ready = 1'($urandom_range(0, 1));
      run_done = prev_run;
      if (sent < 20 && fifo_level < 4'd8) begin
        ib = 5'(sent);
        evt_x = {ib[3:0], 6'h2A}; evt_y = 10'h07F; evt_pol = ib[4]; evt_valid = 1'b1;
        sent++;
      end else begin
        evt_valid = 1'b0;
      end
      prev_v = spk_valid; prev_r = spk_ready; prev_idx = spk_idx; prev_run = run_req;
      cyc();
      guard++;
    end
    evt_valid = 1'b0; run_done = 1'b0; spk_ready = 1'b0;
    checks++;
    if (got.size() !== base + 20) begin
      errors++;
      $display("FAIL bp_count: got %0d spikes, expected 20", got.size() - base);
    end else begin
      for (int k = 0; k < 20; k++) begin
        ib = 5'(k);
        exp_i = {ib[4], 3'b000, ib[3:0]};
        checks++;
        if (got[base + k] !== exp_i) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %0h, expected %0h", k, got[base + k], exp_i);
        end
      end
    end
  endtask

  task automatic test_run_handshake();
    int n;
    int rbase;
    do_reset();
    rbase = run_cnt;
    repeat (5) cyc();
    run_done = 1'b1; cyc(); run_done = 1'b0;
    checks++;
    if (step_cnt !== 16'd0) begin
      errors++;
      $display("FAIL run_stray_collect: got step=%0d, expected 0", step_cnt);
    end
    wait_run(40, n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL run_first_time: got %0d, expected 10", n);
    end
    cyc();
    repeat (50) cyc();
    checks++;
    if (run_cnt !== rbase + 1 || step_cnt !== 16'd0 || run_req !== 1'b0) begin
      errors++;
      $display("FAIL run_wait_done: got pulses=%0d step=%0d run=%0b, expected 1 0 0", run_cnt - rbase, step_cnt, run_req);
    end
    run_done = 1'b1; cyc(); run_done = 1'b0;
    checks++;
    if (step_cnt !== 16'd1) begin
      errors++;
      $display("FAIL run_step1: got %0d, expected 1", step_cnt);
    end
    repeat (3) cyc();
    run_done = 1'b1; cyc(); run_done = 1'b0;
    wait_run(40, n);
    checks++;
    if (n !== 12 || step_cnt !== 16'd1) begin
      errors++;
      $display("FAIL run_second_time: got wait=%0d step=%0d, expected 12 1", n, step_cnt);
    end
    cyc();
    run_done = 1'b1; cyc(); run_done = 1'b0;
    checks++;
    if (step_cnt !== 16'd2 || run_cnt !== rbase + 2) begin
      errors++;
      $display("FAIL run_step2: got step=%0d pulses=%0d, expected 2 2", step_cnt, run_cnt - rbase);
    end
  endtask

  task automatic test_enable_reset();
    int n;
    do_reset();
    repeat (5) cyc();
    enable = 1'b0;
    evt_x = 10'h3FF; evt_y = 10'h3FF; evt_pol = 1'b1; evt_valid = 1'b1;
    repeat (20) cyc();
    evt_valid = 1'b0; enable = 1'b1;
    checks++;
    if (fifo_level !== 4'd0 || drop_cnt !== 16'd0 || spk_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_ignored: got lvl=%0d drop=%0d v=%0b, expected 0 0 0", fifo_level, drop_cnt, spk_valid);
    end
    wait_run(40, n);
    checks++;
    if (n !== 11) begin
      errors++;
      $display("FAIL en_tick_frozen: got %0d cycles to run_req, expected 11", n);
    end
    cyc();
    for (int i = 0; i < 4; i++) push_evt(10'(i << 6), 10'h000, 1'b1);
    checks++;
    if (fifo_level !== 4'd4 || spk_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_wait_buffer: got lvl=%0d v=%0b, expected 4 0", fifo_level, spk_valid);
    end
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({spk_valid, spk_idx, run_req, fifo_level, step_cnt, drop_cnt} !== 46'd0) begin
      errors++;
      $display("FAIL en_reset_outputs: got v=%0b idx=%0h run=%0b lvl=%0d step=%0d drop=%0d, expected all 0",
               spk_valid, spk_idx, run_req, fifo_level, step_cnt, drop_cnt);
    end
    rst_n = 1'b1;
    push_evt(10'h3FF, 10'h3FF, 1'b1);
    checks++;
    if (spk_valid !== 1'b1 || spk_idx !== 8'hFF || fifo_level !== 4'd1) begin
      errors++;
      $display("FAIL en_collect_after_reset: got v=%0b idx=%0h lvl=%0d, expected 1 ff 1", spk_valid, spk_idx, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_boundary_drain();
    test_overflow();
    test_backpressure();
    test_run_handshake();
    test_enable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvs_event_scheduler.md
# dvs_event_scheduler

Sequences decoded DVS address events from the AER receiver into the RAVENS spike-input port and paces RAVENS execution in fixed-length timesteps. Events are buffered in a small FIFO and mapped to an input-neuron index. At each timestep boundary, the scheduler drains exactly the events captured up to that boundary and then issues a run request to RAVENS. It sits between the AER receiver and the RAVENS core inside dvs_ravens.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, at least 2.
- ADDR_W, 10: width of the x/y event address.
- TIMESTEP_CYCLES, 1000: clk cycles of collection per timestep; at least 2.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  gates event capture and the timestep counter.
- evt_valid  input  1  one-cycle strobe: decoded event present.
- evt_x  input  ADDR_W  event x address.
- evt_y  input  ADDR_W  event y address.
- evt_pol  input  1  event polarity.
- spk_valid  output  1  spike index offered to RAVENS.
- spk_idx  output  8  input-neuron index at the FIFO head.
- spk_ready  input  1  RAVENS accepts the spike.
- run_req  output  1  one-cycle pulse: execute one timestep.
- run_done  input  1  RAVENS timestep complete.
- step_cnt  output  16  completed timesteps; wraps.
- drop_cnt  output  16  events dropped due to a full FIFO; saturates at 0xFFFF.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Index map** (computed at push): spk_idx = {evt_pol, evt_y[ADDR_W-1 -: 3], evt_x[ADDR_W-1 -: 4]}.
- **Push:** occurs when evt_valid && enable && level < FIFO_DEPTH, as evaluated at the start of the cycle.
  - A push when full is dropped and increments drop_cnt, even if a pop occurs in the same cycle.
  - evt_valid while enable=0 is ignored and not counted.
- **Pop:** occurs when spk_valid && spk_ready.
- **Simultaneous push and pop** (not full): level is unchanged.
- **States:** COLLECT, DRAIN, RUN, WAIT_DONE.
- **COLLECT**
  - spk_valid = !empty.
  - tick_cnt increments while enable=1 and holds while enable=0.
  - When tick_cnt == TIMESTEP_CYCLES-1 and enable=1:
    - go to DRAIN;
    - drain_rem <= the next-cycle level, i.e. including this cycle's push and pop;
    - tick_cnt <= 0.
    - If the next-cycle level is 0, go directly to RUN.
- **DRAIN**
  - spk_valid = (drain_rem != 0).
  - Each pop decrements drain_rem. When the pop takes drain_rem from 1 to 0, go to RUN.
  - Pushes continue and belong to the next timestep.
- **RUN**
  - run_req = 1 for exactly this cycle; go to WAIT_DONE.
- **WAIT_DONE**
  - spk_valid = 0; pushes continue.
  - On run_done: step_cnt += 1 (mod 2^16), go to COLLECT.
- run_done is ignored in all states other than WAIT_DONE.
- enable=0 does not abort DRAIN, RUN or WAIT_DONE.
- spk_valid, once asserted, holds with a stable spk_idx until it is accepted.

## Timing
- **Reset:** state COLLECT, FIFO empty, tick_cnt=0, drain_rem=0, step_cnt=0, drop_cnt=0. Outputs: spk_valid=0, spk_idx=0, run_req=0, fifo_level=0.
- **Reset mid-operation:** discards buffered events, counters and state; it takes effect at the next edge.
- **Event to spk_valid:** 1 cycle. A push at edge N makes spk_valid high after edge N in COLLECT; spk_idx comes from registered FIFO storage.
- **spk_valid, spk_idx, run_req, fifo_level** are functions of registered state only. There is no combinational path from inputs to outputs.
- **Boundary to run_req:**
  - empty FIFO: the run_req pulse occurs 1 cycle after the boundary cycle.
  - otherwise: drain_rem accepted pops, then RUN.
- **Minimum timestep period:** TIMESTEP_CYCLES + 2 + drained pops + run_done latency.
- **Pointer wrap:** read and write pointers are modulo FIFO_DEPTH. Level is tracked separately, so full and empty are unambiguous.

## Test plan
- **Basic flow** (TIMESTEP_CYCLES=16, spk_ready=1). Stimulus: one event x=0x3FF, y=0x000, pol=1 at cycle 2. Response: spk_valid at cycle 3 with spk_idx=0x8F, popped in that cycle; run_req pulses once after tick 15.
- **Boundary drain** (spk_ready=0 until DRAIN). Stimulus: push 3 events in COLLECT, push 2 more during DRAIN. Response: exactly 3 spikes issued before run_req; the other 2 are issued in the next COLLECT; fifo_level=2 at RUN.
- **Overflow** (FIFO_DEPTH=8, spk_ready=0). Stimulus: 10 consecutive events, including one coinciding with a pop while full. Response: fifo_level=8 and drop_cnt=2; the simultaneous push is dropped.
- **Backpressure.** Stimulus: toggle spk_ready randomly. Response: spk_idx stays stable while valid and not ready; spike order equals push order across pointer wrap (20 events).
- **Run handshake.** Stimulus: delay run_done by 50 cycles and pulse run_done during COLLECT. Response: a stray run_done is ignored; step_cnt increments by 1 per completed step; no run_req occurs while in WAIT_DONE.
- **Enable/reset.** Stimulus: enable=0 for 20 cycles in COLLECT, then rst_n=0 in WAIT_DONE with 4 events buffered. Response: tick_cnt frozen and events ignored with drop_cnt unchanged; after reset all outputs are 0 and state is COLLECT.
